serial_thermometer_counter: RTL and testbench
=============================================

Name: serial_thermometer_counter

Overview:
- Upstream stage of the serial thermometer-to-2's-complement converter.
- Accepts a thermometer code one bit per valid cycle, ones first, and counts the ones.
- Checks that the code is a legal thermometer pattern.
- Presents the 5-bit binary count with a valid/ready handshake; the count drives the 2's-complement lookup address.

Parameters:
- N_BITS, 31, thermometer code length in bits; count range is 0..N_BITS.
- CNT_W, 5, count width; must satisfy 2^CNT_W > N_BITS.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a new conversion; honoured only in IDLE.
- bit_in  input  1  serial thermometer bit; element 0 (first to set) is sent first.
- bit_valid  input  1  bit_in is consumed this cycle; honoured only in SHIFT.
- count  output  CNT_W  registered number of ones received.
- count_valid  output  1  count and therm_error are valid; held until out_ready.
- out_ready  input  1  downstream accepts the count.
- therm_error  output  1  a 1 was received after a 0 (illegal thermometer code).
- busy  output  1  high in SHIFT and DONE.

Behaviour:
- Reset, any state:
  - state=IDLE
  - count=0, count_valid=0, therm_error=0, busy=0
  - internal bit index=0, seen_zero=0
  - An in-progress conversion is abandoned with no output.
- FSM state IDLE:
  - start=1: go to SHIFT.
  - Clear count, bit index, seen_zero and therm_error; keep count_valid=0.
  - bit_valid is ignored.
- FSM state SHIFT:
  - Each cycle with bit_valid=1 consumes bit_in and increments the bit index.
  - bit_in=1: count += 1. If seen_zero=1, set therm_error (sticky until next start).
  - bit_in=0: set seen_zero.
  - Cycles with bit_valid=0 change nothing; any number of gaps is allowed.
  - start is ignored.
  - When the consumed bit is number N_BITS (index N_BITS-1), go to DONE.
- FSM state DONE:
  - count_valid=1; count and therm_error are stable.
  - out_ready=1: return to IDLE and drop count_valid on the next edge.
  - count keeps its value in IDLE until the next start.
  - bit_valid and start are ignored, so start must be re-asserted in IDLE.
- Latency:
  - count_valid rises on the edge after the clock that consumed the last bit.
  - With continuous bit_valid, start-to-count_valid is N_BITS+1 cycles.
  - Same-cycle out_ready and count_valid completes the transfer in one cycle.
- Arithmetic and width:
  - count never exceeds N_BITS, so no wrap is possible.
  - All ones gives count=N_BITS (31 = 5'h1F); all zeros gives 0.
- Illegal code:
  - count equals the total number of ones received, not the position of the first 0.
  - therm_error=1 is reported with that count.
- Simultaneous events:
  - rst has priority over all inputs.
  - start with out_ready in DONE: out_ready is honoured, start is ignored.
- busy is a registered decode of the state (SHIFT or DONE).

Test Plan:
- Reset mid-SHIFT after 10 ones -> next cycle: count=0, busy=0, count_valid=0. New start plus 31 zeros -> count=0, therm_error=0.
- start, then 7 ones and 24 zeros with continuous bit_valid, out_ready=1 -> count_valid high for exactly 1 cycle, 32 cycles after start; count=5'h07, therm_error=0.
- 31 ones -> count=5'h1F; pattern 16 ones then 15 zeros -> count=5'h10; both with therm_error=0.
- Pattern 1,1,0,1 then 27 zeros -> count=3, therm_error=1. Next clean conversion of 5 ones -> therm_error=0.
- Random bit_valid gaps (about 50% duty), 20 ones -> count=5'h14, unaffected by gaps. out_ready held low 5 cycles -> count_valid and count stable for all 5 cycles, then IDLE.
- start pulsed during SHIFT and DONE, bit_valid pulsed in IDLE/DONE -> no state change and no count change.

Source files
------------

// File: rtl/serial_thermometer_counter.sv
// Serial thermometer-code counter: counts ones received one bit per valid cycle,
// flags non-thermometer patterns, and hands the count downstream over valid/ready.
module serial_thermometer_counter #(
  parameter int N_BITS = 31,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             therm_error,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BITS - 1);

  state_t           state;
  logic [CNT_W-1:0] idx;
  logic             seen_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      count_valid <= 1'b0;
      therm_error <= 1'b0;
      busy        <= 1'b0;
      idx         <= '0;
      seen_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // count is held from the last conversion until a new one begins
          if (start) begin
            state       <= SHIFT;
            busy        <= 1'b1;
            count       <= '0;
            idx         <= '0;
            seen_zero   <= 1'b0;
            therm_error <= 1'b0;
          end
        end
        SHIFT: begin
          if (bit_valid) begin
            idx <= idx + CNT_W'(1);
            if (bit_in) begin
              count <= count + CNT_W'(1);
              if (seen_zero) therm_error <= 1'b1;
            end else begin
              seen_zero <= 1'b1;
            end
            if (idx == LAST) state <= DONE;
          end
        end
        DONE: begin
          // valid rises one edge after the last bit; transfer needs valid && ready
          if (!count_valid) begin
            count_valid <= 1'b1;
          end else if (out_ready) begin
            count_valid <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_thermometer_counter.sv
// Scoreboard bench: stimulus pushes hand-computed results, a monitor pops them
// whenever the counter hands a count downstream.
module tb_serial_thermometer_counter;

  logic       clk = 1'b0;
  logic       rst, start, bit_in, bit_valid, out_ready;
  logic [4:0] count;
  logic       count_valid, therm_error, busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0] cnt;
    logic       err;
  } exp_t;

  exp_t sb[$];

  serial_thermometer_counter #(.N_BITS(31), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .out_ready(out_ready), .count(count), .count_valid(count_valid),
    .therm_error(therm_error), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // monitor: every accepted count is compared against the oldest expectation
  always @(negedge clk) begin
    if (!rst && count_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_count", int'(count), int'(e.cnt));
        chk("sb_therm_error", int'(therm_error), int'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one full 31-bit conversion; pat[0] is sent first
  task automatic conv(input logic [30:0] pat, input int ecnt, input logic eerr,
                      input bit gaps, input bit hold, input bit noise);
    exp_t e;
    e.cnt = 5'(ecnt);
    e.err = eerr;
    sb.push_back(e);
    out_ready = !hold;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 31; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) begin
          bit_valid = 1'b0;
          bit_in    = 1'b1;
          tick();
        end
      end
      start     = noise && (i == 3 || i == 10);
      bit_valid = 1'b1;
      bit_in    = pat[i];
      tick();
    end
    bit_valid = 1'b0;
    start     = 1'b0;
    chk("valid_not_early", int'(count_valid), 0);
    chk("busy_after_last_bit", int'(busy), 1);
    if (noise) begin
      start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    end
    tick();
    chk("valid_rise", int'(count_valid), 1);
    chk("count_at_valid", int'(count), ecnt);
    if (hold) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        chk("hold_valid", int'(count_valid), 1);
        chk("hold_count", int'(count), ecnt);
      end
      out_ready = 1'b1;
    end
    tick();
    chk("valid_drop", int'(count_valid), 0);
    chk("idle_busy", int'(busy), 0);
    if (noise) begin
      start = 1'b0;
      repeat (2) tick();
      chk("idle_noise_busy", int'(busy), 0);
      chk("idle_noise_count", int'(count), ecnt);
      chk("idle_noise_valid", int'(count_valid), 0);
      bit_valid = 1'b0;
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(count_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(therm_error), 0);
    rst = 1'b0;
    tick();

    // abandon a conversion mid-SHIFT
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      tick();
    end
    chk("pre_rst_count", int'(count), 10);
    rst = 1'b1; bit_valid = 1'b0;
    tick();
    chk("midrst_count", int'(count), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_valid", int'(count_valid), 0);
    rst = 1'b0;
    tick();

    conv(31'h0000_0000, 0,  1'b0, 0, 0, 0);
    conv(31'h0000_007F, 7,  1'b0, 0, 0, 0);
    conv(31'h7FFF_FFFF, 31, 1'b0, 0, 0, 0);
    conv(31'h0000_FFFF, 16, 1'b0, 0, 0, 0);
    conv(31'h0000_000B, 3,  1'b1, 0, 0, 0);
    conv(31'h0000_001F, 5,  1'b0, 0, 0, 0);
    conv(31'h000F_FFFF, 20, 1'b0, 1, 1, 0);
    conv(31'h0000_0007, 3,  1'b0, 0, 0, 1);

    repeat (3) tick();
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
